// File: rtl/mem_io_responder.sv
// Bus target for the CPU byte bus: RAM pass-through, RX/TX byte FIFOs and a free-running
// cycle counter in the 0x3xxxx I/O window, with CPU stall and sticky program-stop.
module mem_io_responder #(
    parameter int RAM_AW   = 17,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [31:0]       bus_a,
    input  logic              bus_wr,
    input  logic [7:0]        bus_din,
    output logic [7:0]        bus_dout,
    output logic              cpu_rdy_out,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              prog_stop
);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam int TXW = $clog2(TX_DEPTH);

    logic [7:0]  r_rx_mem [RX_DEPTH];
    logic [7:0]  r_tx_mem [TX_DEPTH];
    logic [RXW:0] r_rx_wp, r_rx_rp;
    logic [TXW:0] r_tx_wp, r_tx_rp;
    logic [31:0] r_cnt, r_cnt_snap;
    logic        r_halted;
    logic        r_sel_q;
    logic [7:0]  r_io_q;

    logic        w_io, w_is_00, w_is_04;
    logic        w_rx_pop_req, w_tx_push_req, w_stop;
    logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic        w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic [7:0]  w_tx_push_data, w_io_rdata;
    logic        w_unused;

    assign w_unused = ^bus_a[31:18];

    assign w_io    = (bus_a[17:16] == 2'b11);
    assign w_is_00 = (bus_a[17:0] == 18'h30000);
    assign w_is_04 = (bus_a[17:0] == 18'h30004);

    assign w_rx_pop_req  = ~bus_wr & w_is_00;
    assign w_tx_push_req = bus_wr & ((w_is_00 & (bus_din != 8'h00)) | w_is_04);
    assign w_stop        = bus_wr & w_is_04;
    assign w_tx_push_data = w_is_04 ? 8'h00 : bus_din;

    // Full/empty from the extra pointer MSB; the low bits index storage.
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RXW] != r_rx_rp[RXW]) && (r_rx_wp[RXW-1:0] == r_rx_rp[RXW-1:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TXW] != r_tx_rp[TXW]) && (r_tx_wp[TXW-1:0] == r_tx_rp[TXW-1:0]);

    assign cpu_rdy_out = ~r_halted & ~(w_rx_pop_req & w_rx_empty) & ~(w_tx_push_req & w_tx_full);

    assign w_rx_push = rx_valid & ~w_rx_full;
    assign w_rx_pop  = w_rx_pop_req & cpu_rdy_out;
    assign w_tx_push = w_tx_push_req & cpu_rdy_out;
    assign w_tx_pop  = ~w_tx_empty & tx_ready;

    assign ram_a     = bus_a[RAM_AW-1:0];
    assign ram_wdata = bus_din;
    assign ram_we    = bus_wr & ~w_io & cpu_rdy_out;

    assign rx_ready  = ~w_rx_full;
    assign tx_valid  = ~w_tx_empty;
    assign tx_data   = r_tx_mem[r_tx_rp[TXW-1:0]];
    assign prog_stop = r_halted;
    assign bus_dout  = r_sel_q ? r_io_q : ram_rdata;

    always_comb begin
        w_io_rdata = 8'h00;
        case (bus_a[17:0])
            18'h30000: w_io_rdata = r_rx_mem[r_rx_rp[RXW-1:0]];
            18'h30004: w_io_rdata = r_cnt[7:0];
            18'h30005: w_io_rdata = r_cnt_snap[15:8];
            18'h30006: w_io_rdata = r_cnt_snap[23:16];
            18'h30007: w_io_rdata = r_cnt_snap[31:24];
            default:   w_io_rdata = 8'h00;
        endcase
    end

    // Storage is not reset: clearing the pointers discards the contents.
    always_ff @(posedge clk_in) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[RXW-1:0]] <= rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wp[TXW-1:0]] <= w_tx_push_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_cnt      <= 32'd0;
            r_cnt_snap <= 32'd0;
            r_halted   <= 1'b0;
            r_sel_q    <= 1'b1;
            r_io_q     <= 8'h00;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (cpu_rdy_out) begin
                r_sel_q <= w_io;
                r_io_q  <= w_io_rdata;
                if (w_io & ~bus_wr & w_is_04) r_cnt_snap <= r_cnt;
                if (w_io & w_stop)            r_halted   <= 1'b1;
            end
            if (w_rx_push) r_rx_wp <= r_rx_wp + (RXW+1)'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + (RXW+1)'(1);
            if (w_tx_push) r_tx_wp <= r_tx_wp + (TXW+1)'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + (TXW+1)'(1);
        end
    end
endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed vector table, hand sequences for
// stalls/snapshot/stop/reset, and random traffic against a queue-based reference model.
module tb_mem_io_responder;
    localparam int RXD = 16;
    localparam int TXD = 16;

    logic        clk_in, rst_in;
    logic [31:0] bus_a;
    logic        bus_wr;
    logic [7:0]  bus_din, bus_dout;
    logic        cpu_rdy_out;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, prog_stop;
    logic [7:0]  rx_data, tx_data;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .bus_a(bus_a), .bus_wr(bus_wr), .bus_din(bus_din),
        .bus_dout(bus_dout), .cpu_rdy_out(cpu_rdy_out), .ram_a(ram_a), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .prog_stop(prog_stop)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // External synchronous RAM
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_wdata;
        ram_rdata <= ram_mem[ram_a];
    end

    // Reference model state
    logic [7:0]  ref_mem [0:131071];
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic        m_halted;
    logic [31:0] m_cyc, m_snap;

    int checks = 0;
    int errors = 0;
    logic last_commit;
    logic seen_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_halted = 1'b0;
        m_cyc = 32'd0;
        m_snap = 32'd0;
        last_commit = 1'b1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_dout", 32'(bus_dout), 32'h0);
        chk("rst_rdy", 32'(cpu_rdy_out), 32'h1);
        chk("rst_prog_stop", 32'(prog_stop), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, advance model at the edge,
    // then check registered outputs at the following negedge.
    task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] din,
                        input logic rxv, input logic [7:0] rxd, input logic txr);
        logic [17:0] ad;
        logic io, rxpop, txpush, stop, exp_rdy, rx_in, tx_out;
        logic [7:0] rdv;
        bus_a = a; bus_wr = wr; bus_din = din;
        rx_valid = rxv; rx_data = rxd; tx_ready = txr;
        ad = a[17:0];
        io = (ad[17:16] == 2'b11);
        rxpop = io && !wr && ad == 18'h30000;
        txpush = io && wr && ((ad == 18'h30000 && din != 8'h00) || ad == 18'h30004);
        stop = io && wr && ad == 18'h30004;
        exp_rdy = !m_halted && !(rxpop && rxq.size() == 0) && !(txpush && txq.size() == TXD);
        #1;
        seen_rdy = cpu_rdy_out;
        chk("cpu_rdy", 32'(cpu_rdy_out), 32'(exp_rdy));
        chk("ram_we", 32'(ram_we), 32'(wr && !io && exp_rdy));
        rdv = 8'h00;
        if (!io)                                    rdv = ref_mem[ad[16:0]];
        else if (ad == 18'h30000 && rxq.size() > 0) rdv = rxq[0];
        else if (ad == 18'h30004)                   rdv = m_cyc[7:0];
        else if (ad == 18'h30005)                   rdv = m_snap[15:8];
        else if (ad == 18'h30006)                   rdv = m_snap[23:16];
        else if (ad == 18'h30007)                   rdv = m_snap[31:24];
        rx_in = rxv && rxq.size() < RXD;
        tx_out = txq.size() > 0 && txr;
        @(posedge clk_in);
        if (exp_rdy) begin
            if (io && !wr && ad == 18'h30004) m_snap = m_cyc;
            if (rxpop) void'(rxq.pop_front());
            if (wr && !io) ref_mem[ad[16:0]] = din;
            if (stop) m_halted = 1'b1;
        end
        if (tx_out) void'(txq.pop_front());
        if (exp_rdy && txpush) txq.push_back(stop ? 8'h00 : din);
        if (rx_in) rxq.push_back(rxd);
        m_cyc = m_cyc + 32'd1;
        last_commit = exp_rdy;
        @(negedge clk_in);
        if (exp_rdy && !wr) chk("bus_dout", 32'(bus_dout), 32'(rdv));
        chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
        if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
        chk("rx_ready", 32'(rx_ready), 32'(rxq.size() < RXD));
        chk("prog_stop", 32'(prog_stop), 32'(m_halted));
    endtask

    task automatic idle(input logic txr);
        step(32'h0, 1'b0, 8'h00, 1'b0, 8'h00, txr);
    endtask

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  din;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[12];
    logic [7:0] b[4];
    logic [31:0] snap_exp;
    logic [31:0] ra;
    logic rwr;
    logic [7:0] rdin;

    initial begin
        for (int i = 0; i < 131072; i++) begin
            ram_mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        ram_rdata = 8'h00;
        bus_a = 32'h0; bus_wr = 1'b0; bus_din = 8'h00;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        rst_in = 1'b1;
        #1 rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        check_reset_outputs();
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();

        vecs[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
        vecs[2]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[4]  = '{32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00};
        vecs[5]  = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C};
        vecs[6]  = '{32'h0002_0005, 1'b1, 8'h77, 1'b0, 8'h00};
        vecs[7]  = '{32'h0000_0005, 1'b0, 8'h00, 1'b1, 8'h77};
        vecs[8]  = '{32'hFFFC_0005, 1'b0, 8'h00, 1'b1, 8'h77};
        vecs[9]  = '{32'h0003_FFFF, 1'b1, 8'h55, 1'b0, 8'h00};
        vecs[10] = '{32'h0003_FFFF, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[11] = '{32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h00};
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].a, vecs[i].wr, vecs[i].din, 1'b0, 8'h00, 1'b1);
            if (vecs[i].chk) chk($sformatf("vec%0d_dout", i), 32'(bus_dout), 32'(vecs[i].exp));
        end
        chk("zero_write_tx_valid", 32'(tx_valid), 32'h0);

        // RX empty stall, no bypass on a simultaneous push
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("rx_stall_empty", 32'(seen_rdy), 32'h0);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b1);
        chk("rx_stall_nobypass", 32'(seen_rdy), 32'h0);
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("rx_commit", 32'(seen_rdy), 32'h1);
        chk("rx_byte", 32'(bus_dout), 32'h41);

        // TX full: 17th write stalls; a same-cycle pop does not free space
        for (int i = 0; i < TXD + 1; i++) begin
            step(32'h0003_0000, 1'b1, 8'(i + 1), 1'b0, 8'h00, 1'b0);
            chk($sformatf("tx_fill%0d_rdy", i), 32'(seen_rdy), 32'(i < TXD));
        end
        step(32'h0003_0000, 1'b1, 8'd17, 1'b0, 8'h00, 1'b1);
        chk("tx_full_pop_same_cycle", 32'(seen_rdy), 32'h0);
        step(32'h0003_0000, 1'b1, 8'd17, 1'b0, 8'h00, 1'b0);
        chk("tx_full_commit", 32'(seen_rdy), 32'h1);
        for (int k = 2; k <= 17; k++) begin
            chk("tx_order", 32'(tx_data), 32'(k));
            idle(1'b1);
        end
        chk("tx_drained", 32'(tx_valid), 32'h0);

        // Counter snapshot across a carry out of byte 0
        for (int g = 0; g < 300 && m_cyc[7:0] != 8'hFF; g++) idle(1'b1);
        snap_exp = m_cyc;
        for (int i = 0; i < 4; i++) begin
            step(32'h0003_0004 + 32'(i), 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
            b[i] = bus_dout;
        end
        chk("snap_byte0", 32'(b[0]), 32'hFF);
        chk("snap_word", {b[3], b[2], b[1], b[0]}, snap_exp);

        // Random traffic, bus held while stalled
        for (int n = 0; n < 600; n++) begin
            if (last_commit) begin
                rwr = 1'b0;
                rdin = 8'($urandom);
                case ($urandom_range(0, 7))
                    0, 1, 7: begin
                        ra = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 1)) << 16)
                             | 32'($urandom_range(0, 31));
                        rwr = 1'($urandom_range(0, 1));
                    end
                    2, 3: ra = ($urandom & 32'hFFFC_0000) | 32'h0003_0000;
                    4: begin
                        ra = 32'h0003_0000;
                        rwr = 1'b1;
                        if ($urandom_range(0, 3) == 0) rdin = 8'h00;
                    end
                    5: ra = 32'h0003_0004 + 32'($urandom_range(0, 3));
                    default: begin
                        ra = 32'h0003_0008 + 32'($urandom_range(0, 7));
                        rwr = 1'($urandom_range(0, 1));
                    end
                endcase
            end
            step(ra, rwr, rdin, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int g = 0; g < 40; g++) idle(1'b1);
        for (int g = 0; g < 20 && rxq.size() > 0; g++)
            step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Program stop: 0x00 on TX, sticky halt, counter keeps running
        step(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
        chk("stop_commit", 32'(seen_rdy), 32'h1);
        chk("stop_flag", 32'(prog_stop), 32'h1);
        chk("stop_tx_zero", 32'(tx_data), 32'h00);
        for (int i = 0; i < 4; i++) begin
            step(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00, 1'(i == 3));
            chk("halted_rdy", 32'(seen_rdy), 32'h0);
            chk("halted_cnt", dut.r_cnt, m_cyc);
        end
        chk("halted_tx_drained", 32'(tx_valid), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        idle(1'b1);
        chk("after_reset_rdy", 32'(seen_rdy), 32'h1);

        // Async reset while halted with both FIFOs half full
        for (int i = 0; i < 8; i++) step(32'h0, 1'b0, 8'h00, 1'b1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(32'h0003_0000, 1'b1, 8'(8'h80 + i), 1'b0, 8'h00, 1'b0);
        step(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0004, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("pre_reset_halted", 32'(seen_rdy), 32'h0);
        #2 rst_in = 1'b0;
        #1;
        check_reset_outputs();
        chk("async_rst_cnt", dut.r_cnt, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        model_reset();
        step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("rx_discarded", 32'(seen_rdy), 32'h0);
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
